// File: rtl/hazard_ctrl.sv
// Hazard scheduler: D-stage stall plus D/E forwarding selects from E/M/W writer slots.
// Define HAZ_MDU_EN to add the mult/div busy counter and its extra stall.
module hazard_ctrl #(
    parameter int unsigned MD_LAT = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] az_d,
    input  logic [5:0] aw_d,
    input  logic [5:0] am_d,
    input  logic [1:0] tuse_z,
    input  logic [1:0] tuse_w,
    input  logic [1:0] tuse_m,
    input  logic [5:0] ax_d,
    input  logic [1:0] tnew_d,
    input  logic       md_use_d,
    input  logic       md_start,
    output logic       stall,
    output logic [1:0] fwd_dz,
    output logic [1:0] fwd_dw,
    output logic [1:0] fwd_ez,
    output logic [1:0] fwd_ew,
    output logic [1:0] fwd_em,
    output logic       md_busy
);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_E    = 2'b01;
    localparam logic [1:0] SRC_M    = 2'b10;
    localparam logic [1:0] SRC_W    = 2'b11;

    logic [5:0] r_e_ax;
    logic [1:0] r_e_tnew;
    logic [5:0] r_e_az;
    logic [5:0] r_e_aw;
    logic [5:0] r_e_am;
    logic       r_e_vld;
    logic [5:0] r_m_ax;
    logic [1:0] r_m_tnew;
    logic [5:0] r_w_ax;

    logic [1:0] w_sel_z;
    logic [1:0] w_sel_w;
    logic [1:0] w_sel_m;
    logic [1:0] w_tn_z;
    logic [1:0] w_tn_w;
    logic [1:0] w_tn_m;
    logic       w_haz_z;
    logic       w_haz_w;
    logic       w_haz_m;
    logic       w_stall_md;

    // Youngest writer slot holding a GPR address; 0 and selectors never match.
    function automatic logic [1:0] f_sel(
        input logic [5:0] a,
        input logic [5:0] ex,
        input logic [5:0] mx,
        input logic [5:0] wx
    );
        logic [1:0] s;
        s = SRC_NONE;
        if (a != 6'd0 && !a[5]) begin
            if (a == ex) begin
                s = SRC_E;
            end else if (a == mx) begin
                s = SRC_M;
            end else if (a == wx) begin
                s = SRC_W;
            end
        end
        return s;
    endfunction

    function automatic logic [1:0] f_tnew(
        input logic [1:0] sel,
        input logic [1:0] et,
        input logic [1:0] mt
    );
        logic [1:0] t;
        case (sel)
            SRC_E:   t = et;
            SRC_M:   t = mt;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    assign w_sel_z = f_sel(az_d, r_e_ax, r_m_ax, r_w_ax);
    assign w_sel_w = f_sel(aw_d, r_e_ax, r_m_ax, r_w_ax);
    assign w_sel_m = f_sel(am_d, r_e_ax, r_m_ax, r_w_ax);

    assign w_tn_z = f_tnew(w_sel_z, r_e_tnew, r_m_tnew);
    assign w_tn_w = f_tnew(w_sel_w, r_e_tnew, r_m_tnew);
    assign w_tn_m = f_tnew(w_sel_m, r_e_tnew, r_m_tnew);

    assign w_haz_z = (w_sel_z != SRC_NONE) && (w_tn_z > tuse_z);
    assign w_haz_w = (w_sel_w != SRC_NONE) && (w_tn_w > tuse_w);
    assign w_haz_m = (w_sel_m != SRC_NONE) && (w_tn_m > tuse_m);

    assign stall = w_haz_z | w_haz_w | w_haz_m | w_stall_md;

    // A not-yet-ready writer yields 00 here; a later stage picks it up.
    assign fwd_dz = (w_sel_z != SRC_NONE && w_tn_z == 2'd0) ? w_sel_z : SRC_NONE;
    assign fwd_dw = (w_sel_w != SRC_NONE && w_tn_w == 2'd0) ? w_sel_w : SRC_NONE;

    assign fwd_ez = f_sel(r_e_az, 6'd0, r_m_ax, r_w_ax);
    assign fwd_ew = f_sel(r_e_aw, 6'd0, r_m_ax, r_w_ax);
    assign fwd_em = f_sel(r_e_am, 6'd0, r_m_ax, r_w_ax);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_ax   <= '0;
            r_e_tnew <= '0;
            r_e_az   <= '0;
            r_e_aw   <= '0;
            r_e_am   <= '0;
            r_e_vld  <= 1'b0;
            r_m_ax   <= '0;
            r_m_tnew <= '0;
            r_w_ax   <= '0;
        end else begin
            r_w_ax   <= r_m_ax;
            r_m_ax   <= r_e_ax;
            r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
            if (stall) begin
                r_e_ax   <= '0;
                r_e_tnew <= '0;
                r_e_az   <= '0;
                r_e_aw   <= '0;
                r_e_am   <= '0;
                r_e_vld  <= 1'b0;
            end else begin
                r_e_ax   <= ax_d;
                r_e_tnew <= tnew_d;
                r_e_az   <= az_d;
                r_e_aw   <= aw_d;
                r_e_am   <= am_d;
                r_e_vld  <= 1'b1;
            end
        end
    end

`ifdef HAZ_MDU_EN
    logic [3:0] r_md_cnt;
    logic       w_md_go;

    // A bubbled E slot cannot start the unit.
    assign w_md_go = md_start & r_e_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (w_md_go) begin
            r_md_cnt <= 4'(MD_LAT);
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    assign md_busy    = (r_md_cnt != 4'd0);
    assign w_stall_md = md_use_d & (md_busy | w_md_go);
`else
    logic w_unused;

    assign w_unused   = ^{md_use_d, md_start, r_e_vld, 4'(MD_LAT)};
    assign md_busy    = 1'b0;
    assign w_stall_md = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal cases plus random traffic vs a
// cycle-timestamp model of in-flight writers.
module tb_hazard_ctrl;

    localparam int MD_LAT = 5;
`ifdef HAZ_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] az_d, aw_d, am_d, ax_d;
    logic [1:0] tuse_z, tuse_w, tuse_m, tnew_d;
    logic       md_use_d, md_start;
    logic       stall, md_busy;
    logic [1:0] fwd_dz, fwd_dw, fwd_ez, fwd_ew, fwd_em;

    hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
        .clk(clk), .reset(reset),
        .az_d(az_d), .aw_d(aw_d), .am_d(am_d),
        .tuse_z(tuse_z), .tuse_w(tuse_w), .tuse_m(tuse_m),
        .ax_d(ax_d), .tnew_d(tnew_d),
        .md_use_d(md_use_d), .md_start(md_start),
        .stall(stall),
        .fwd_dz(fwd_dz), .fwd_dw(fwd_dw),
        .fwd_ez(fwd_ez), .fwd_ew(fwd_ew), .fwd_em(fwd_em),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Each in-flight instruction remembers the absolute cycle its result exists.
    typedef struct {
        bit         vld;
        logic [5:0] ax;
        logic [5:0] az;
        logic [5:0] aw;
        logic [5:0] am;
        int         rdy;
    } slot_t;

    slot_t pipe[3];
    int    cyc = 0;
    int    md_last = 0;
    bit    md_on = 1'b0;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %b want %b", nm, cyc, act, exp);
        end
    endtask

    function automatic bit gpr(input logic [5:0] a);
        return a != 6'd0 && !a[5];
    endfunction

    function automatic int remain(input int k);
        return (pipe[k].rdy > cyc) ? pipe[k].rdy - cyc : 0;
    endfunction

    function automatic int youngest(input logic [5:0] a, input int first);
        for (int k = first; k < 3; k++)
            if (gpr(a) && pipe[k].vld && pipe[k].ax == a) return k;
        return -1;
    endfunction

    function automatic bit op_stall(input logic [5:0] a, input logic [1:0] tu);
        int k;
        k = youngest(a, 0);
        return k >= 0 && remain(k) > int'(tu);
    endfunction

    function automatic logic [1:0] m_fwd_d(input logic [5:0] a);
        int k;
        k = youngest(a, 0);
        if (k >= 0 && remain(k) == 0) return 2'(k + 1);
        return 2'b00;
    endfunction

    function automatic logic [1:0] m_fwd_e(input logic [5:0] a);
        int k;
        k = youngest(a, 1);
        return (k >= 0) ? 2'(k + 1) : 2'b00;
    endfunction

    function automatic bit m_busy();
        return MDU && md_on && cyc > md_last && cyc <= md_last + MD_LAT;
    endfunction

    function automatic bit m_go();
        return MDU && md_start && pipe[0].vld;
    endfunction

    function automatic bit m_stall();
        return op_stall(az_d, tuse_z) || op_stall(aw_d, tuse_w) ||
               op_stall(am_d, tuse_m) || (md_use_d && (m_busy() || m_go()));
    endfunction

    always @(posedge clk) begin
        bit st;
        if (reset) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 0};
            md_on = 1'b0;
        end else begin
            st = m_stall();
            if (m_go()) begin
                md_on   = 1'b1;
                md_last = cyc;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st)
                pipe[0] = '{1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 0};
            else
                pipe[0] = '{1'b1, ax_d, az_d, aw_d, am_d, cyc + 1 + int'(tnew_d)};
        end
        cyc++;
    end

    always @(negedge clk) begin
        chk("m_stall", {1'b0, stall}, {1'b0, m_stall()});
        chk("m_fwd_dz", fwd_dz, m_fwd_d(az_d));
        chk("m_fwd_dw", fwd_dw, m_fwd_d(aw_d));
        chk("m_fwd_ez", fwd_ez, m_fwd_e(pipe[0].az));
        chk("m_fwd_ew", fwd_ew, m_fwd_e(pipe[0].aw));
        chk("m_fwd_em", fwd_em, m_fwd_e(pipe[0].am));
        chk("m_md_busy", {1'b0, md_busy}, {1'b0, m_busy()});
    end

    task automatic idle_in();
        az_d = '0; aw_d = '0; am_d = '0; ax_d = '0;
        tuse_z = 2'd3; tuse_w = 2'd3; tuse_m = 2'd3; tnew_d = 2'd0;
        md_use_d = 1'b0; md_start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        idle_in();
        repeat (3) tick();
    endtask

    function automatic logic [5:0] rnd_a();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 8) return 6'h20;
        if (r == 9) return 6'h22;
        return 6'(r);
    endfunction

    initial begin
        int  ns;
        bit  done;
        reset = 1'b1;
        idle_in();
        tick();
        tick();
        reset = 1'b0;
        #2;
        chk("rst_stall", {1'b0, stall}, 2'b00);
        chk("rst_fwd_dz", fwd_dz, 2'b00);
        chk("rst_fwd_ez", fwd_ez, 2'b00);
        chk("rst_busy", {1'b0, md_busy}, 2'b00);
        tick();

        // load-use: lw $2 then addu rs=$2 needed in E
        ax_d = 6'd2; tnew_d = 2'd2; #2;
        chk("lw_nostall", {1'b0, stall}, 2'b00);
        tick();
        idle_in(); az_d = 6'd2; tuse_z = 2'd1; ax_d = 6'd5; #2;
        chk("lu_stall", {1'b0, stall}, 2'b01);
        tick(); #2;
        chk("lu_release", {1'b0, stall}, 2'b00);
        chk("lu_dz", fwd_dz, 2'b00);
        tick(); idle_in(); #2;
        chk("lu_ez_w", fwd_ez, 2'b11);
        tick(); flush();

        // ALU result needed by branch in D
        ax_d = 6'd3; tnew_d = 2'd1; tick();
        idle_in(); az_d = 6'd3; tuse_z = 2'd0; #2;
        chk("br_stall", {1'b0, stall}, 2'b01);
        tick(); #2;
        chk("br_release", {1'b0, stall}, 2'b00);
        chk("br_dz_m", fwd_dz, 2'b10);
        tick(); flush();

        // two writers of $4, store data takes the younger
        ax_d = 6'd4; tick();
        ax_d = 6'd4; tick();
        idle_in(); am_d = 6'd4; tuse_m = 2'd2; #2;
        chk("sw_nostall", {1'b0, stall}, 2'b00);
        tick(); idle_in(); #2;
        chk("sw_em_m", fwd_em, 2'b10);
        tick(); flush();

        // $0 and selector destinations
        ax_d = 6'd0; tnew_d = 2'd2; tick();
        idle_in(); ax_d = 6'h20; tnew_d = 2'd2; tick();
        idle_in(); az_d = 6'h20; aw_d = 6'd0; am_d = 6'h20;
        tuse_z = 2'd0; tuse_w = 2'd0; tuse_m = 2'd0; #2;
        chk("sel_stall", {1'b0, stall}, 2'b00);
        chk("sel_dz", fwd_dz, 2'b00);
        chk("sel_dw", fwd_dw, 2'b00);
        tick(); idle_in(); #2;
        chk("sel_ez", fwd_ez, 2'b00);
        chk("sel_em", fwd_em, 2'b00);
        tick(); flush();

        // D forward from W, then from E
        ax_d = 6'd7; tick();
        idle_in(); tick(); tick();
        az_d = 6'd7; tuse_z = 2'd0; #2;
        chk("dz_w", fwd_dz, 2'b11);
        tick();
        idle_in(); ax_d = 6'd8; tick();
        idle_in(); aw_d = 6'd8; tuse_w = 2'd1; #2;
        chk("dw_e", fwd_dw, 2'b01);
        chk("dw_nostall", {1'b0, stall}, 2'b00);
        tick(); flush();

        // reset while stalled
        ax_d = 6'd9; tnew_d = 2'd2; tick();
        idle_in(); az_d = 6'd9; tuse_z = 2'd0; #2;
        chk("rs_stall", {1'b0, stall}, 2'b01);
        reset = 1'b1; tick(); reset = 1'b0; #2;
        chk("rs_cleared", {1'b0, stall}, 2'b00);
        tick(); flush();

        // mult/div start followed by mflo
        idle_in(); tick();
        md_start = 1'b1; md_use_d = 1'b1;
        ns = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #2;
            if (stall) ns++;
            else done = 1'b1;
            tick();
            md_start = 1'b0;
        end
        n_vec++;
        if (ns != (MDU ? MD_LAT + 1 : 0)) begin
            n_err++;
            $display("FAIL md_stall_len: got %0d want %0d", ns, MDU ? MD_LAT + 1 : 0);
        end
        flush();

        for (int i = 0; i < 3000; i++) begin
            az_d = rnd_a(); aw_d = rnd_a(); am_d = rnd_a(); ax_d = rnd_a();
            tuse_z = 2'($urandom_range(0, 3));
            tuse_w = 2'($urandom_range(0, 3));
            tuse_m = 2'($urandom_range(0, 3));
            tnew_d = 2'($urandom_range(0, 2));
            md_use_d = ($urandom_range(0, 7) == 0);
            md_start = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
